// File: rtl/div_tick_timer.sv
// Countdown timer that counts rising edges of one selected divided-clock bit,
// emitting a tick per counted edge and a done pulse when the count reaches zero.
module div_tick_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    div_in,
    input  logic [2:0]    sel,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] load_val,
    output logic          tick,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state, state_nxt;
    logic [7:0]    div_q;
    logic [7:0]    rise;
    logic [2:0]    sel_q, sel_nxt;
    logic [CW-1:0] count_nxt;
    logic          tick_nxt;

    assign rise = div_in & ~div_q;
    assign busy = (state == S_RUN);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        sel_nxt   = sel_q;
        count_nxt = count;
        tick_nxt  = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel_nxt   = sel;
                        count_nxt = load_val;
                        state_nxt = (load_val != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    // The zero guard keeps the count from ever wrapping.
                    if (rise[sel_q] && (count != '0)) begin
                        count_nxt = count - ONE;
                        tick_nxt  = 1'b1;
                        if (count == ONE) state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            div_q <= '0;
            sel_q <= '0;
            count <= '0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            div_q <= div_in;
            sel_q <= sel_nxt;
            count <= count_nxt;
            tick  <= tick_nxt;
            done  <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_div_tick_timer.sv
// Self-checking bench for div_tick_timer: free-running divider stimulus, random
// countdowns and aborts, checked against an arithmetic edge-position model.
module tb_div_tick_timer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    div_in;
    logic [2:0]    sel;
    logic          start;
    logic          abort;
    logic [CW-1:0] load_val;
    logic          tick;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    logic [7:0] div_cnt = 8'd0;
    logic [7:0] div_manual = 8'd0;
    bit         div_free = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Divider stage model: bit k of a free-running counter has period 2^(k+1).
    always @(posedge clk) div_cnt <= div_cnt + 8'd1;
    assign div_in = div_free ? div_cnt : div_manual;

    div_tick_timer #(.CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .sel      (sel),
        .start    (start),
        .abort    (abort),
        .load_val (load_val),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // Starts a countdown and checks every cycle until it finishes or is aborted.
    // A rise of bit s is sampled at the edge where the counter value is 2^s mod 2^(s+1).
    task automatic run_countdown(input int s, input int n, input int abort_hits,
                                 input bit poke, input string tag);
        int v0, c, hits, fin_c, abort_c, per;
        bit aborted, abort_now, hit;
        logic          e_tick, e_busy, e_done;
        logic [CW-1:0] e_count;
        per = 1 << (s + 1);
        @(negedge clk);
        v0 = int'(div_cnt);
        sel = 3'(s);
        load_val = CW'(n);
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sel = 3'($urandom);
        load_val = CW'($urandom);
        c = 0; hits = 0; fin_c = (n == 0) ? 0 : -1;
        aborted = 1'b0; abort_now = 1'b0; abort_c = -1;
        while (c < 1500) begin
            hit = 1'b0;
            if (abort_now) begin
                aborted = 1'b1;
                abort_c = c;
            end else if (!aborted && c >= 1 && hits < n && ((v0 + c) % per) == per / 2) begin
                hit = 1'b1;
                hits++;
                if (hits == n) fin_c = c;
            end
            abort_now = 1'b0;
            if (aborted) begin
                e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_count = '0;
            end else begin
                e_tick  = hit;
                e_busy  = (hits < n);
                e_done  = (fin_c == c);
                e_count = CW'(n - hits);
            end
            n_cmp++;
            if ({tick, busy, done, count} !== {e_tick, e_busy, e_done, e_count}) begin
                n_bad++;
                $display("FAIL %s cycle %0d: tick/busy/done/count got %b/%b/%b/%0d required %b/%b/%b/%0d",
                         tag, c, tick, busy, done, count, e_tick, e_busy, e_done, e_count);
            end
            start = 1'b0;
            abort = 1'b0;
            if (!aborted && abort_hits >= 0 && hits == abort_hits && fin_c < 0) begin
                abort = 1'b1;
                abort_now = 1'b1;
            end
            if (poke && c == 0) begin
                start = 1'b1;
                sel = 3'($urandom);
                load_val = CW'($urandom);
            end
            if ((fin_c >= 0 && c > fin_c) || (aborted && c > abort_c + 2)) break;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (c >= 1500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: countdown still active after %0d cycles, required completion", tag, c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 3'd0; load_val = '0;
        #3;
        n_cmp++;
        if ({tick, busy, done, count} !== {3'b000, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_state: tick/busy/done/count got %b/%b/%b/%0d required 0/0/0/0",
                     tick, busy, done, count);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        sel = 3'd1; load_val = CW'(10); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_busy: busy got %b required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tick, busy, done, count} !== {3'b000, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL rst_mid_run: tick/busy/done/count got %b/%b/%b/%0d required 0/0/0/0",
                     tick, busy, done, count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, count} !== {1'b0, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL rst_wait_idle: busy/count got %b/%0d required 0/0", busy, count);
        end
        run_countdown(1, 10, -1, 1'b0, "rst_rerun");
    endtask

    task automatic test_basic;
        run_countdown(0, 3, -1, 1'b0, "sel0_n3");
        run_countdown(7, 2, -1, 1'b0, "sel7_n2");
    endtask

    task automatic test_zero_load;
        run_countdown(int'($urandom_range(0, 7)), 0, -1, 1'b0, "zero_load");
    endtask

    task automatic test_abort;
        run_countdown(2, 5, 2, 1'b1, "abort_after2");
    endtask

    task automatic test_abort_with_start;
        @(negedge clk);
        start = 1'b1; abort = 1'b1; load_val = CW'(200); sel = 3'($urandom);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({tick, busy, done, count} !== {3'b000, {CW{1'b0}}}) begin
                n_bad++;
                $display("FAIL abort_start cycle %0d: tick/busy/done/count got %b/%b/%b/%0d required 0/0/0/0",
                         i, tick, busy, done, count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_coincident_rise;
        div_free = 1'b0;
        div_manual = 8'h00;
        @(negedge clk);
        div_manual = 8'h01; sel = 3'd0; load_val = CW'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({tick, busy, done, count} !== {3'b010, CW'(1)}) begin
                n_bad++;
                $display("FAIL coincident_rise cycle %0d: tick/busy/done/count got %b/%b/%b/%0d required 0/1/0/1",
                         i, tick, busy, done, count);
            end
            @(negedge clk);
        end
        div_manual = 8'h00;
        @(negedge clk);
        div_manual = 8'h01;
        @(negedge clk);
        n_cmp++;
        if ({tick, busy, done, count} !== {3'b101, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL later_rise: tick/busy/done/count got %b/%b/%b/%0d required 1/0/1/0",
                     tick, busy, done, count);
        end
        @(negedge clk);
        n_cmp++;
        if ({tick, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL after_done: tick/busy/done got %b/%b/%b required 0/0/0", tick, busy, done);
        end
        div_free = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max_load;
        run_countdown(0, (1 << CW) - 1, -1, 1'b0, "max_load");
    endtask

    task automatic test_random;
        int s, n, ah;
        for (int i = 0; i < 10; i++) begin
            s  = int'($urandom_range(0, 4));
            n  = int'($urandom_range(0, 6));
            ah = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
            run_countdown(s, n, ah, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_load;
        test_abort;
        test_abort_with_start;
        test_coincident_rise;
        test_reset_mid_run;
        test_max_load;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
